// File: rtl/conv_depth_accum.sv
// Streaming depth accumulator: sums D channel slices of a W*K partial-sum row in place,
// adds per-filter bias, requantises each lane and hands the row downstream over valid/ready.

module conv_depth_lane #(
  parameter int PSUM_W  = 32,
  parameter int BIAS_W  = 32,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic               i_acc_en,
  input  logic               i_first,
  input  logic [PSUM_W-1:0]  i_psum,
  input  logic [BIAS_W-1:0]  i_bias,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_relu,
  output logic [OUT_W-1:0]   o_q,
  output logic               o_clip
);
  // One extra bit so adding the rounding constant can never overflow.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] MAXV = RW'(2**(OUT_W-1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_base, w_sum;
  logic signed [RW-1:0]    w_x, w_rnd, w_xr, w_r, w_rr;

  // The first channel of a group reloads from bias, so no explicit clear of r_acc is needed.
  assign w_base = i_first ? ACC_W'($signed(i_bias)) : r_acc;
  assign w_sum  = w_base + ACC_W'($signed(i_psum));

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i)       r_acc <= '0;
    else if (i_acc_en) r_acc <= w_sum;
  end

  assign w_x   = RW'(w_sum);
  assign w_rnd = (i_shift == '0) ? '0 : (RW'(1) << (i_shift - 1'b1));
  assign w_xr  = w_x + w_rnd;
  assign w_r   = w_xr >>> i_shift;
  assign w_rr  = (i_relu && w_r[RW-1]) ? '0 : w_r;

  always_comb begin
    o_clip = 1'b0;
    o_q    = w_rr[OUT_W-1:0];
    if (w_rr > MAXV) begin
      o_q    = MAXV[OUT_W-1:0];
      o_clip = 1'b1;
    end else if (w_rr < MINV) begin
      o_q    = MINV[OUT_W-1:0];
      o_clip = 1'b1;
    end
  end
endmodule

module conv_depth_accum #(
  parameter int D       = 4,
  parameter int W       = 12,
  parameter int K       = 4,
  parameter int PSUM_W  = 32,
  parameter int BIAS_W  = 32,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5,
  localparam int CNT_W  = (D > 1) ? $clog2(D) : 1
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic [PSUM_W*W*K-1:0] psum_i,
  input  logic                  psum_valid_i,
  output logic                  psum_ready_o,
  input  logic [BIAS_W*K-1:0]   bias_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  input  logic                  relu_en_i,
  output logic [CNT_W-1:0]      depth_idx_o,
  output logic [OUT_W*W*K-1:0]  out_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  sat_o
);
  localparam int NL = W * K;

  logic [CNT_W-1:0]            r_cnt;
  logic [SHIFT_W-1:0]          r_shift;
  logic                        r_relu;
  logic [NL-1:0][OUT_W-1:0]    r_out;
  logic                        r_valid;
  logic                        r_sat;

  logic                        w_accept, w_first, w_last, w_relu;
  logic [SHIFT_W-1:0]          w_shift;
  logic [NL-1:0][OUT_W-1:0]    w_q;
  logic [NL-1:0]               w_clip;

  assign psum_ready_o = rstn_i & ~clear_i & (~r_valid | out_ready_i);
  assign w_accept     = psum_valid_i & psum_ready_o;
  assign w_first      = (r_cnt == '0);
  assign w_last       = (r_cnt == CNT_W'(D - 1));
  // Channel 0 uses the live config (needed when D=1); later channels use the latched copy.
  assign w_shift      = w_first ? shift_i   : r_shift;
  assign w_relu       = w_first ? relu_en_i : r_relu;

  for (genvar j = 0; j < NL; j++) begin : g_lane
    conv_depth_lane #(
      .PSUM_W(PSUM_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
    ) u_lane (
      .clk      (clk),
      .rstn_i   (rstn_i),
      .i_acc_en (w_accept),
      .i_first  (w_first),
      .i_psum   (psum_i[j*PSUM_W +: PSUM_W]),
      .i_bias   (bias_i[(j/W)*BIAS_W +: BIAS_W]),
      .i_shift  (w_shift),
      .i_relu   (w_relu),
      .o_q      (w_q[j]),
      .o_clip   (w_clip[j])
    );
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else if (clear_i) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      if (out_ready_i) r_valid <= 1'b0;
      if (w_accept) begin
        if (w_first) begin
          r_shift <= shift_i;
          r_relu  <= relu_en_i;
        end
        if (w_last) begin
          r_cnt   <= '0;
          r_out   <= w_q;
          r_valid <= 1'b1;
          if (|w_clip) r_sat <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign depth_idx_o = r_cnt;
  assign out_o       = r_out;
  assign out_valid_o = r_valid;
  assign sat_o       = r_sat;
endmodule

// File: tb/tb_conv_depth_accum.sv
// Randomised scoreboard bench for conv_depth_accum, plus a small D=1 instance.
module tb_conv_depth_accum;
  localparam int D = 4, W = 12, K = 4, PSUM_W = 32, BIAS_W = 32, ACC_W = 40;
  localparam int OUT_W = 8, SHIFT_W = 5, NL = W * K, CW = 2;
  localparam int W1 = 2;
  localparam longint MAXO = 2**(OUT_W-1) - 1;
  localparam longint MINO = -(2**(OUT_W-1));

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  rstn_i, clear_i, psum_valid_i, psum_ready_o, relu_en_i;
  logic [PSUM_W*NL-1:0]  psum_i;
  logic [BIAS_W*K-1:0]   bias_i;
  logic [SHIFT_W-1:0]    shift_i;
  logic [CW-1:0]         depth_idx_o;
  logic [OUT_W*NL-1:0]   out_o;
  logic                  out_valid_o, out_ready_i, sat_o;

  conv_depth_accum #(.D(D), .W(W), .K(K), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W),
                     .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rstn_i(rstn_i), .clear_i(clear_i), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
    .psum_ready_o(psum_ready_o), .bias_i(bias_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
    .depth_idx_o(depth_idx_o), .out_o(out_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .sat_o(sat_o));

  logic                  d1_valid, d1_ready, d1_relu, d1_ovalid, d1_sat;
  logic [PSUM_W*W1-1:0]  d1_psum;
  logic [BIAS_W-1:0]     d1_bias;
  logic [SHIFT_W-1:0]    d1_shift;
  logic [0:0]            d1_idx;
  logic [OUT_W*W1-1:0]   d1_out;

  conv_depth_accum #(.D(1), .W(W1), .K(1)) dut1 (
    .clk(clk), .rstn_i(rstn_i), .clear_i(1'b0), .psum_i(d1_psum), .psum_valid_i(d1_valid),
    .psum_ready_o(d1_ready), .bias_i(d1_bias), .shift_i(d1_shift), .relu_en_i(d1_relu),
    .depth_idx_o(d1_idx), .out_o(d1_out), .out_valid_o(d1_ovalid),
    .out_ready_i(1'b1), .sat_o(d1_sat));

  int total = 0, bad = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference arithmetic: floor division and requantisation straight from the rules.
  function automatic longint floordiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint rq(input longint x, input int s, input bit relu, output bit clip);
    longint r;
    clip = 1'b0;
    if (s > 0) r = floordiv(x + (longint'(1) << (s - 1)), longint'(1) << s);
    else       r = x;
    if (relu && r < 0) r = 0;
    if (r > MAXO) begin r = MAXO; clip = 1'b1; end
    if (r < MINO) begin r = MINO; clip = 1'b1; end
    return r;
  endfunction

  // Model: group sums per lane, config latched at channel 0, sticky saturation.
  longint p_lane[NL];
  longint p_bias[K];
  longint m_sum[NL];
  int     m_cnt, m_sh;
  bit     m_relu, m_sat;
  logic [OUT_W*NL-1:0] exp_q[$];
  bit                  exp_sat_q[$];

  task automatic model_reset();
    m_cnt = 0; m_sat = 1'b0;
    exp_q.delete(); exp_sat_q.delete();
  endtask

  task automatic model_accept(input int sh, input bit relu);
    logic [OUT_W*NL-1:0] row;
    bit c;
    if (m_cnt == 0) begin
      m_sh = sh; m_relu = relu;
      foreach (m_sum[j]) m_sum[j] = p_bias[j / W] + p_lane[j];
    end else begin
      foreach (m_sum[j]) m_sum[j] = m_sum[j] + p_lane[j];
    end
    if (m_cnt == D - 1) begin
      row = '0;
      foreach (m_sum[j]) begin
        row[j*OUT_W +: OUT_W] = OUT_W'(rq(m_sum[j], m_sh, m_relu, c));
        if (c) m_sat = 1'b1;
      end
      exp_q.push_back(row);
      exp_sat_q.push_back(m_sat);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive_inputs(input int sh, input bit relu);
    for (int j = 0; j < NL; j++) psum_i[j*PSUM_W +: PSUM_W] = PSUM_W'(p_lane[j]);
    for (int k = 0; k < K; k++)  bias_i[k*BIAS_W +: BIAS_W] = BIAS_W'(p_bias[k]);
    shift_i      = SHIFT_W'(sh);
    relu_en_i    = relu;
    psum_valid_i = 1'b1;
  endtask

  // Offer one channel; a stalled consumer is released after one wait cycle.
  task automatic beat(input int sh, input bit relu);
    int n = 0;
    drive_inputs(sh, relu);
    forever begin
      @(negedge clk);
      if (psum_ready_o) break;
      n++;
      if (n > 20) begin
        check("beat_timeout", 1, 0);
        psum_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
      out_ready_i = 1'b1;
    end
    model_accept(sh, relu);
    @(posedge clk); #1;
    psum_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill(input longint v, input longint b);
    foreach (p_lane[j]) p_lane[j] = v;
    foreach (p_bias[k]) p_bias[k] = b;
  endtask

  task automatic fill_rand();
    foreach (p_lane[j]) p_lane[j] = longint'($signed($urandom())) >>> $urandom_range(0, 24);
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1; psum_valid_i = 1'b1;
    @(negedge clk);
    check("clear_blocks_ready", longint'(psum_ready_o), 0);
    @(posedge clk); #1;
    clear_i = 1'b0; psum_valid_i = 1'b0;
    model_reset();
  endtask

  // Monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rstn_i && out_valid_o && out_ready_i && !clear_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [OUT_W*NL-1:0] e;
        bit es;
        e = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        total++;
        if (out_o !== e) begin
          bad++;
          for (int j = 0; j < NL; j++)
            if (out_o[j*OUT_W +: OUT_W] !== e[j*OUT_W +: OUT_W]) begin
              $display("FAIL row lane %0d: got %0d expected %0d", j,
                       $signed(out_o[j*OUT_W +: OUT_W]), $signed(e[j*OUT_W +: OUT_W]));
              break;
            end
        end
        check("sat_sticky_at_output", longint'(sat_o), longint'(es));
      end
    end
  end

  task automatic d1_beat(input longint a, input longint b, input longint bias, input int sh,
                         input bit relu);
    bit c;
    d1_psum  = {PSUM_W'(b), PSUM_W'(a)};
    d1_bias  = BIAS_W'(bias);
    d1_shift = SHIFT_W'(sh);
    d1_relu  = relu;
    d1_valid = 1'b1;
    @(negedge clk);
    check("d1_ready", longint'(d1_ready), 1);
    @(posedge clk); #1;
    d1_valid = 1'b0;
    check("d1_valid_next", longint'(d1_ovalid), 1);
    check("d1_lane0", longint'($signed(d1_out[OUT_W-1:0])), rq(a + bias, sh, relu, c));
    check("d1_lane1", longint'($signed(d1_out[2*OUT_W-1:OUT_W])), rq(b + bias, sh, relu, c));
    idle(1);
    check("d1_valid_drop", longint'(d1_ovalid), 0);
  endtask

  initial begin
    int c0;
    rstn_i = 1'b0; clear_i = 1'b0; psum_valid_i = 1'b0; out_ready_i = 1'b1;
    psum_i = '0; bias_i = '0; shift_i = '0; relu_en_i = 1'b0;
    d1_valid = 1'b0; d1_psum = '0; d1_bias = '0; d1_shift = '0; d1_relu = 1'b0;
    model_reset();
    #1;
    check("ready_in_reset", longint'(psum_ready_o), 0);
    idle(3);
    rstn_i = 1'b1;
    #1;
    check("rst_valid", longint'(out_valid_o), 0);
    check("rst_sat", longint'(sat_o), 0);
    check("rst_depth", longint'(depth_idx_o), 0);
    check("rst_out_zero", longint'(out_o == '0), 1);
    check("rst_ready_after", longint'(psum_ready_o), 1);

    d1_beat(100, -9, 3, 1, 1'b0);
    d1_beat(-50, 300, 0, 0, 1'b1);

    // Basic sum and latency
    fill(10, 5);
    for (int i = 0; i < D; i++) begin
      check("depth_idx_seq", longint'(depth_idx_o), i);
      if (i == D - 1) check("valid_before_last", longint'(out_valid_o), 0);
      beat(2, 1'b0);
    end
    check("valid_after_last", longint'(out_valid_o), 1);
    check("depth_wrap", longint'(depth_idx_o), 0);
    idle(2);

    // Negatives, relu, lane-distinct saturation
    fill(-7, 0);
    repeat (D) beat(1, 1'b0);
    repeat (D) beat(1, 1'b1);
    foreach (p_lane[j]) p_lane[j] = j;
    repeat (D) beat(0, 1'b0);
    idle(2);
    check("sat_after_lanes", longint'(sat_o), 1);

    // Saturation both ways, then clear
    fill(1000, 0);
    repeat (D) beat(0, 1'b0);
    fill(-1000, 0);
    repeat (D) beat(0, 1'b0);
    idle(2);
    clear_pulse();
    check("sat_cleared", longint'(sat_o), 0);
    check("depth_after_clear", longint'(depth_idx_o), 0);

    // Backpressure and same-cycle handoff
    fill(10, 5);
    out_ready_i = 1'b0;
    repeat (D) beat(2, 1'b0);
    fill(3, 1);
    drive_inputs(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready_low", longint'(psum_ready_o), 0);
      check("bp_valid_held", longint'(out_valid_o), 1);
      check("bp_out_stable", longint'(out_o == exp_q[0]), 1);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    beat(0, 1'b0);
    check("handoff_depth", longint'(depth_idx_o), 1);
    check("handoff_valid_drop", longint'(out_valid_o), 0);
    repeat (D - 1) beat(0, 1'b0);

    // Continuous streaming, shift changing every channel
    c0 = cyc;
    for (int g = 0; g < 3; g++) begin
      foreach (p_bias[k]) p_bias[k] = longint'($signed($urandom()));
      for (int i = 0; i < D; i++) begin
        fill_rand();
        beat($urandom_range(0, 31), 1'($urandom_range(0, 1)));
      end
    end
    check("stream_cycles", longint'(cyc - c0), 3 * D);

    // Random consumer stalls
    for (int g = 0; g < 3; g++) begin
      foreach (p_bias[k]) p_bias[k] = longint'($signed($urandom())) >>> 8;
      for (int i = 0; i < D; i++) begin
        fill_rand();
        out_ready_i = 1'($urandom_range(0, 1));
        beat($urandom_range(0, 20), 1'($urandom_range(0, 1)));
      end
    end
    out_ready_i = 1'b1;
    idle(2);

    // Shift latched at channel 0 only
    fill(10, 5);
    beat(2, 1'b0); beat(0, 1'b0); beat(7, 1'b1); beat(0, 1'b1);
    idle(2);

    // Abort mid-group, then a clean group
    fill_rand();
    beat(3, 1'b0); beat(3, 1'b0);
    clear_pulse();
    fill(10, 5);
    repeat (D) beat(2, 1'b0);
    idle(2);

    // Clear drops a pending output
    out_ready_i = 1'b0;
    repeat (D) beat(2, 1'b0);
    check("pending_valid", longint'(out_valid_o), 1);
    clear_pulse();
    check("clear_drops_valid", longint'(out_valid_o), 0);
    out_ready_i = 1'b1;

    // Asynchronous reset with a pending, saturated output
    out_ready_i = 1'b0;
    fill(1000, 0);
    repeat (D) beat(0, 1'b0);
    #2 rstn_i = 1'b0;
    #1;
    check("async_rst_valid", longint'(out_valid_o), 0);
    check("async_rst_sat", longint'(sat_o), 0);
    check("async_rst_ready", longint'(psum_ready_o), 0);
    model_reset();
    idle(1);
    rstn_i = 1'b1; out_ready_i = 1'b1;

    // Asynchronous reset mid-group
    fill(10, 5);
    beat(2, 1'b0); beat(2, 1'b0);
    check("mid_depth", longint'(depth_idx_o), 2);
    #2 rstn_i = 1'b0;
    #1;
    check("async_rst_depth", longint'(depth_idx_o), 0);
    model_reset();
    idle(1);
    rstn_i = 1'b1;
    repeat (D) beat(2, 1'b0);
    idle(4);

    check("queue_drained", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
